xc_pclmul_seq: RTL and testbench

XC_PCLMUL_SEQ -- requirements
Module: xc_pclmul_seq

---
 rtl/xc_pclmul_seq.sv | 134 +++++++++++++
 tb/tb_xc_pclmul_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_pclmul_seq.sv
// Iterative packed carry-less multiplier: XLEN/W independent lanes, STEP multiplier
// bits per lane per cycle, reporting the low or high half of each lane product.
module xc_pclmul_seq #(
  parameter int STEP = 1,
  parameter int XLEN = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            valid,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      pw,
  input  logic            hi,
  output logic            ready,
  output logic [XLEN-1:0] result
);

  localparam int AW  = $clog2(XLEN);
  localparam int AW2 = $clog2(2 * XLEN);
  localparam int CW  = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  logic [XLEN-1:0]     a_q, b_q;
  logic [2:0]          lsh_q;
  logic                hi_q;
  logic [CW-1:0]       cnt, last_cnt;
  logic [2*XLEN-1:0]   acc, acc_nxt;
  logic                accept;

  // Lane width is XLEN >> lsh; lowest set pw bit wins, pw=0 falls back to full width.
  function automatic logic [2:0] decode_pw(input logic [4:0] p);
    decode_pw = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (p[i]) decode_pw = 3'(i);
  endfunction

  // One iteration: fold multiplier bits i with i/STEP == c into each lane's 2W slice.
  function automatic logic [2*XLEN-1:0] step_acc(input logic [2*XLEN-1:0] acc_in,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b,
                                                 input logic [2:0] lsh,
                                                 input logic [CW-1:0] c);
    logic [2*XLEN-1:0] r;
    r = acc_in;
    for (int si = 0; si < 5; si++) begin
      if (lsh == 3'(si)) begin
        for (int k = 0; k < (1 << si); k++)
          for (int i = 0; i < (XLEN >> si); i++)
            if (CW'(i / STEP) == c && b[AW'((XLEN >> si) * k + i)])
              for (int t = 0; t < (XLEN >> si); t++)
                r[AW2'(2 * (XLEN >> si) * k + i + t)] = r[AW2'(2 * (XLEN >> si) * k + i + t)]
                                                       ^ a[AW'((XLEN >> si) * k + t)];
      end
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] select_half(input logic [2*XLEN-1:0] acc_in,
                                                  input logic [2:0] lsh,
                                                  input logic h);
    logic [XLEN-1:0] r;
    r = '0;
    for (int si = 0; si < 5; si++) begin
      if (lsh == 3'(si)) begin
        for (int k = 0; k < (1 << si); k++)
          for (int t = 0; t < (XLEN >> si); t++)
            r[AW'((XLEN >> si) * k + t)] =
              acc_in[AW2'(2 * (XLEN >> si) * k + t + (h ? (XLEN >> si) : 0))];
      end
    end
    return r;
  endfunction

  assign accept  = (state == IDLE) && valid && !flush && !g_reset;
  assign acc_nxt = step_acc(acc, a_q, b_q, lsh_q, cnt);

  // Final counter value: ceil(W/STEP)-1, one cycle minimum when W <= STEP.
  always_comb begin
    last_cnt = '0;
    for (int si = 0; si < 5; si++)
      if (lsh_q == 3'(si) && (XLEN >> si) > STEP)
        last_cnt = CW'((XLEN >> si) / STEP - 1);
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY: begin
        if (flush || !valid)     state_nxt = IDLE;
        else if (cnt == last_cnt) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state == DONE) && !flush && !g_reset;
    result = ready ? select_half(acc, lsh_q, hi_q) : '0;
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      cnt <= '0;
      acc <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
      acc <= acc_nxt;
    end
  end

  // Operand capture happens only on acceptance; later input changes are ignored.
  always_ff @(posedge g_clk) begin
    if (accept) begin
      a_q   <= rs1;
      b_q   <= rs2;
      lsh_q <= decode_pw(pw);
      hi_q  <= hi;
    end
  end

endmodule

// File: tb/tb_xc_pclmul_seq.sv
// Directed bench for xc_pclmul_seq: STEP=1 and STEP=4 instances, vector table plus
// flush/reset/valid-drop corner sequences.
module tb_xc_pclmul_seq;

  logic        g_clk;
  logic        g_reset, flush, hi;
  logic        valid1, valid4;
  logic [31:0] rs1, rs2;
  logic [4:0]  pw;
  logic        ready1, ready4;
  logic [31:0] result1, result4;

  int n_vec = 0;
  int n_bad = 0;

  xc_pclmul_seq #(.STEP(1), .XLEN(32)) dut1 (
    .g_clk(g_clk), .g_reset(g_reset), .valid(valid1), .flush(flush),
    .rs1(rs1), .rs2(rs2), .pw(pw), .hi(hi), .ready(ready1), .result(result1));

  xc_pclmul_seq #(.STEP(4), .XLEN(32)) dut4 (
    .g_clk(g_clk), .g_reset(g_reset), .valid(valid4), .flush(flush),
    .rs1(rs1), .rs2(rs2), .pw(pw), .hi(hi), .ready(ready4), .result(result4));

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  p;
    logic        h;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  function automatic logic rdy(input bit sel);
    return sel ? ready4 : ready1;
  endfunction

  function automatic logic [31:0] res(input bit sel);
    return sel ? result4 : result1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] p, input logic h);
    rs1 = a; rs2 = b; pw = p; hi = h;
    valid1 = !sel;
    valid4 = sel;
  endtask

  task automatic scramble();
    rs1 = $urandom;
    rs2 = $urandom;
    pw  = 5'($urandom);
    hi  = 1'($urandom);
  endtask

  task automatic start_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] p, input logic h);
    @(negedge g_clk);
    drive(sel, a, b, p, h);
    @(posedge g_clk);
    #1;
    scramble();
  endtask

  // Called just after the acceptance edge; returns the cycle index in which ready is seen.
  task automatic wait_ready(input bit sel, input int budget, output int cyc, output bit zok);
    cyc = 0;
    zok = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge g_clk);
      if (rdy(sel)) begin
        cyc = c;
        break;
      end
      if (res(sel) != 32'h0) zok = 1'b0;
      @(posedge g_clk);
    end
  endtask

  task automatic expect_quiet(input bit sel, input int cycles, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge g_clk);
      if (rdy(sel)) seen = 1'b1;
    end
    check(name, seen, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    bit zok;
    start_op(v.sel, v.a, v.b, v.p, v.h);
    wait_ready(v.sel, 60, cyc, zok);
    check({tag, " latency"}, cyc, v.lat);
    check({tag, " result"}, res(v.sel), v.exp);
    check({tag, " zero-before-ready"}, zok, 1);
    valid1 = 1'b0;
    valid4 = 1'b0;
    @(negedge g_clk);
    check({tag, " single-pulse"}, rdy(v.sel), 0);
  endtask

  initial begin
    int cyc;
    bit zok;

    g_reset = 1'b1; valid1 = 1'b0; valid4 = 1'b0; flush = 1'b0;
    rs1 = '0; rs2 = '0; pw = '0; hi = 1'b0;

    vecs[0]  = '{0, 32'h00000003, 32'h00000003, 5'b00001, 1'b0, 32'h00000005, 33};
    vecs[1]  = '{0, 32'h80000000, 32'h80000000, 5'b00001, 1'b1, 32'h40000000, 33};
    vecs[2]  = '{0, 32'h80000000, 32'h80000000, 5'b00001, 1'b0, 32'h00000000, 33};
    vecs[3]  = '{0, 32'h03030303, 32'h03030303, 5'b00100, 1'b0, 32'h05050505, 9};
    vecs[4]  = '{0, 32'h03030303, 32'h03030303, 5'b00100, 1'b1, 32'h00000000, 9};
    vecs[5]  = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00010, 1'b1, 32'h55555555, 5};
    vecs[6]  = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00010, 1'b0, 32'h55555555, 5};
    vecs[7]  = '{1, 32'h00000003, 32'h00000003, 5'b00001, 1'b0, 32'h00000005, 9};
    vecs[8]  = '{0, 32'hFFFFFFFF, 32'hAAAAAAAA, 5'b10000, 1'b0, 32'hAAAAAAAA, 3};
    vecs[9]  = '{0, 32'hFFFFFFFF, 32'hAAAAAAAA, 5'b10000, 1'b1, 32'h55555555, 3};
    vecs[10] = '{0, 32'h00000003, 32'h00000005, 5'b00000, 1'b0, 32'h0000000F, 33};
    vecs[11] = '{1, 32'h03030303, 32'h03030303, 5'b01100, 1'b0, 32'h05050505, 3};
    vecs[12] = '{1, 32'hFFFFFFFF, 32'h11111111, 5'b01000, 1'b0, 32'hFFFFFFFF, 2};
    vecs[13] = '{1, 32'hFFFFFFFF, 32'hAAAAAAAA, 5'b10000, 1'b1, 32'h55555555, 2};
    vecs[14] = '{0, 32'h88888888, 32'h88888888, 5'b01000, 1'b1, 32'h44444444, 5};
    vecs[15] = '{0, 32'h00FF0001, 32'h00030101, 5'b00010, 1'b0, 32'h01010101, 17};
    vecs[16] = '{0, 32'h80808080, 32'h80808080, 5'b00100, 1'b1, 32'h40404040, 9};
    vecs[17] = '{0, 32'h80808080, 32'h80808080, 5'b00100, 1'b0, 32'h00000000, 9};

    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    check("reset ready1", ready1, 0);
    check("reset result1", result1, 0);
    check("reset ready4", ready4, 0);
    check("reset result4", result4, 0);
    g_reset = 1'b0;

    for (int i = 0; i < 18; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Flush in BUSY cycle 5; the next op is accepted in cycle 6 and must be on time.
    start_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b0);
    repeat (4) @(posedge g_clk);
    @(negedge g_clk);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    drive(0, 32'h3, 32'h3, 5'b00001, 1'b0);
    @(posedge g_clk);
    #1;
    scramble();
    wait_ready(0, 60, cyc, zok);
    check("flush-busy next latency", cyc, 33);
    check("flush-busy next result", result1, 32'h5);
    valid1 = 1'b0;
    @(negedge g_clk);

    // Reset in the DONE cycle.
    start_op(0, 32'h03030303, 32'h03030303, 5'b00100, 1'b0);
    wait_ready(0, 20, cyc, zok);
    check("rst-done latency", cyc, 9);
    g_reset = 1'b1;
    #1;
    check("rst-done ready", ready1, 0);
    check("rst-done result", result1, 0);
    @(posedge g_clk);
    @(negedge g_clk);
    check("rst-done ready after", ready1, 0);
    check("rst-done result after", result1, 0);
    g_reset = 1'b0;
    valid1 = 1'b0;
    run_vec(vecs[3], "after-reset");

    // Flush in the DONE cycle suppresses the pulse.
    start_op(1, 32'h03030303, 32'h03030303, 5'b00100, 1'b0);
    wait_ready(1, 20, cyc, zok);
    check("flush-done latency", cyc, 3);
    flush = 1'b1;
    #1;
    check("flush-done ready", ready4, 0);
    check("flush-done result", result4, 0);
    @(posedge g_clk);
    @(negedge g_clk);
    flush = 1'b0;
    valid4 = 1'b0;
    check("flush-done ready after", ready4, 0);

    // Valid dropped mid-operation aborts it.
    start_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b0);
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    valid1 = 1'b0;
    expect_quiet(0, 40, "valid-drop no ready");

    // Reset mid-operation discards it; a fresh op right after must run from scratch.
    start_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b0);
    @(negedge g_clk);
    g_reset = 1'b1;
    @(negedge g_clk);
    g_reset = 1'b0;
    drive(1, 32'h3, 32'h3, 5'b00001, 1'b0);
    @(posedge g_clk);
    #1;
    scramble();
    wait_ready(1, 20, cyc, zok);
    check("rst-mid next latency", cyc, 9);
    check("rst-mid next result", result4, 32'h5);
    valid4 = 1'b0;
    @(negedge g_clk);

    // Valid with flush in IDLE is not accepted; acceptance happens one cycle later.
    @(negedge g_clk);
    drive(0, 32'h3, 32'h3, 5'b00001, 1'b0);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    @(posedge g_clk);
    #1;
    scramble();
    wait_ready(0, 60, cyc, zok);
    check("flush-idle latency", cyc, 33);
    check("flush-idle result", result1, 32'h5);
    valid1 = 1'b0;
    @(negedge g_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
